ctrl_datapath_fsm: RTL
======================

Name: ctrl_datapath_fsm

Overview:
- Multicycle control sequencer for the MIPS-subset datapath.
- It is the driver side of the operand-select interface. It generates mux_b_control, mux_a_control and alu_control, plus register, memory and PC enables, on every cycle.
- Moore-style FSM. Inputs are the decoded instruction fields and the ALU zero flag. Outputs go directly to the datapath muxes and register enables.

Parameters:
WAIT_CYCLES, 1, extra memory-latency cycles in FETCH and MEM_READ (range 0..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  6  instruction bits [31:26] from IR
funct  input  6  instruction bits [5:0] from IR
zero  input  1  ALU zero flag
mux_a_control  output  1  0=PC, 1=regA
mux_b_control  output  2  00=regB, 01=constant 4, 10=sign-extend16_32, 11=sign-extend shifted left 2
alu_control  output  3  001=add, 010=sub, 011=and; 000 when idle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  conditional PC load, gated by branch_ne/zero
branch_ne  output  1  1: PC loads when zero=0; 0: PC loads when zero=1
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
iord  output  1  memory address select: 0=PC, 1=ALUOut
mem_wr  output  1  memory write strobe
ir_write  output  1  IR load
a_b_load  output  1  regA/regB load
alu_out_load  output  1  ALUOut load
reg_write  output  1  register-file write
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode or funct

Behaviour:
- Reset: asynchronous and active-high. Asserting reset forces state RESET immediately. All outputs are 0 in RESET.
- After reset deasserts, RESET lasts exactly 1 cycle, then the FSM goes to FETCH.
- Reset during any state aborts the instruction. No write strobe may be asserted after reset asserts.
- Outputs decode combinationally from the current state. Exceptions: alu_control in EXEC_R depends on funct; branch_ne in BRANCH depends on opcode. Any output not listed for a state is 0.
- A wait counter (3 bit) loads WAIT_CYCLES on entry to FETCH and MEM_READ and decrements each cycle. It is 0 in all other states.
- FETCH:
  - Every cycle: iord=0.
  - Final cycle only (counter==0): mux_a=0, mux_b=01, alu=add, pc_source=00, pc_write=1, ir_write=1.
  - Duration: WAIT_CYCLES+1 cycles, then DECODE.
- DECODE (1 cycle):
  - Outputs: mux_a=0, mux_b=11, alu=add, alu_out_load=1 (branch target), a_b_load=1.
  - Next state by opcode:
    - 0x00 with funct 0x20/0x22/0x24 -> EXEC_R
    - 0x08 -> EXEC_I
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - anything else -> illegal_op=1, next FETCH; no state is modified.
- EXEC_R: mux_a=1, mux_b=00, alu_control from funct (0x20 add, 0x22 sub, 0x24 and), alu_out_load=1 -> WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I: mux_a=1, mux_b=10, alu=add, alu_out_load=1 -> WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- MEM_ADDR: mux_a=1, mux_b=10, alu=add, alu_out_load=1 -> MEM_READ (0x23) or MEM_WRITE (0x2B). The opcode held in IR is stable.
- MEM_READ: iord=1 for WAIT_CYCLES+1 cycles -> WB_LOAD.
- WB_LOAD: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WRITE: iord=1, mem_wr=1, exactly 1 cycle -> FETCH.
- BRANCH: mux_a=1, mux_b=00, alu=sub, pc_source=01, pc_write_cond=1, branch_ne=0 -> FETCH.
- JUMP: pc_source=10, pc_write=1 -> FETCH.
- Mutual exclusion: pc_write and pc_write_cond are never both 1. Likewise ir_write and mem_wr.
- Latency with WAIT_CYCLES=1:
  - R-type 5 cycles, addi 5, lw 7, sw 5, beq 4, j 4, illegal 3.
- Unused state encodings recover to FETCH on the next edge.

Optional Feature:
- Macro: CTRL_BNE_EN.
- Defined: opcode 0x05 (bne) is decoded in DECODE and goes to BRANCH. In BRANCH, branch_ne=1 and all other BRANCH outputs are the same as for beq.
- Undefined: opcode 0x05 is illegal (illegal_op pulse, return to FETCH), and branch_ne is tied to 0.

Test Plan:
- Reset asserted mid-MEM_WRITE -> mem_wr falls to 0 in the same cycle (async). One RESET cycle after deassert, then FETCH. All outputs are 0 during reset.
- add (opcode 0x00, funct 0x20), WAIT_CYCLES=1 -> FETCH x2 (ir_write/pc_write only on the 2nd), DECODE with mux_b=11, EXEC_R with mux_b=00 and alu=001, WB_R with reg_write=1 and reg_dst=1; 5 cycles total.
- lw 0x23, WAIT_CYCLES=0 and then 3 -> MEM_ADDR with mux_b=10; MEM_READ lasts 1 and then 4 cycles with iord=1; WB_LOAD with mem_to_reg=1; totals 5 and 11 cycles.
- beq 0x04 -> BRANCH with mux_a=1, mux_b=00, alu=010, pc_source=01, pc_write_cond=1, branch_ne=0; back to FETCH after 4 cycles (WAIT_CYCLES=1).
- Opcode 0x3F, then R-type funct 0x2A -> illegal_op=1 for exactly the DECODE cycle. reg_write, mem_wr and pc_write stay 0. Next state is FETCH.
- Opcode 0x05 with CTRL_BNE_EN defined -> BRANCH with branch_ne=1. Without the macro -> illegal_op pulse.

Source files
------------

// File: rtl/ctrl_datapath_fsm.sv
// ctrl_datapath_fsm: Moore-style multicycle control sequencer for the
// MIPS-subset datapath. It drives the operand-select muxes, the ALU function
// and the register/memory/PC enables every cycle, decoded from the current state.
//
// Optional build macro: CTRL_BNE_EN. When it is defined, bne (opcode 0x05) is
// decoded and branch_ne is driven in BRANCH. When it is not defined, 0x05 is
// illegal and branch_ne is tied low.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   opcode, funct       IR[31:26] and IR[5:0]
//   zero                ALU zero flag (the datapath gates PC loads with it)
//   mux_a_control       0=PC, 1=regA
//   mux_b_control       00=regB, 01=4, 10=sext imm, 11=sext imm<<2
//   alu_control         001 add, 010 sub, 011 and, 000 idle
//   pc_write, pc_write_cond, branch_ne, pc_source   PC update controls
//   iord, mem_wr, ir_write                          memory/IR controls
//   a_b_load, alu_out_load                          internal register loads
//   reg_write, reg_dst, mem_to_reg                  register-file write-back
//   illegal_op          one-cycle pulse in DECODE for an unsupported encoding
module ctrl_datapath_fsm #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       mux_a_control,
  output logic [1:0] mux_b_control,
  output logic [2:0] alu_control,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_wr,
  output logic       ir_write,
  output logic       a_b_load,
  output logic       alu_out_load,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_ADDR, S_MEM_READ, S_WB_LOAD, S_MEM_WRITE, S_BRANCH, S_JUMP
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;

  // zero is consumed by the datapath's PC gating; the sequencer is pure Moore.
  logic unused_zero;
  assign unused_zero = zero;

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RESET;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state    = state;
    cnt_next      = '0;
    mux_a_control = 1'b0;
    mux_b_control = 2'b00;
    alu_control   = 3'b000;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_wr        = 1'b0;
    ir_write      = 1'b0;
    a_b_load      = 1'b0;
    alu_out_load  = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;

    case (state)
      S_RESET: next_state = S_FETCH;
      S_FETCH: begin
        // Instruction is latched and PC+4 written only on the last wait cycle.
        if (cnt == '0) begin
          mux_b_control = 2'b01;
          alu_control   = ALU_ADD;
          pc_write      = 1'b1;
          ir_write      = 1'b1;
          next_state    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch target while registers are read.
        mux_b_control = 2'b11;
        alu_control   = ALU_ADD;
        alu_out_load  = 1'b1;
        a_b_load      = 1'b1;
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) begin
              next_state = S_EXEC_R;
            end else begin
              illegal_op = 1'b1;
              next_state = S_FETCH;
            end
          end
          OP_ADDI:      next_state = S_EXEC_I;
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_BEQ:       next_state = S_BRANCH;
`ifdef CTRL_BNE_EN
          OP_BNE:       next_state = S_BRANCH;
`endif
          OP_J:         next_state = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        mux_a_control = 1'b1;
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          default: alu_control = 3'b000;
        endcase
        alu_out_load = 1'b1;
        next_state   = S_WB_R;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = S_FETCH;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        mux_a_control = 1'b1;
        mux_b_control = 2'b10;
        alu_control   = ALU_ADD;
        alu_out_load  = 1'b1;
        if (state == S_EXEC_I)     next_state = S_WB_I;
        else if (opcode == OP_LW)  next_state = S_MEM_READ;
        else                       next_state = S_MEM_WRITE;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_READ: begin
        iord = 1'b1;
        if (cnt == '0) next_state = S_WB_LOAD;
      end
      S_WB_LOAD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        iord       = 1'b1;
        mem_wr     = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        mux_a_control = 1'b1;
        alu_control   = ALU_SUB;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
`ifdef CTRL_BNE_EN
        branch_ne     = (opcode == OP_BNE);
`endif
        next_state    = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase

    // Wait counter: count down inside a waiting state, reload on entry.
    if ((state == S_FETCH || state == S_MEM_READ) && cnt != '0) begin
      cnt_next = cnt - CNT_W'(1);
    end else if (next_state == S_FETCH || next_state == S_MEM_READ) begin
      cnt_next = WAIT_LOAD;
    end
  end

endmodule
